// File: rtl/rr_arbiter.sv
// rr_arbiter: N-requester arbiter with a registered, held grant.
//
// A grant is issued one clock after arbitration and held until the grantee
// pulses done or drops its own request. Winner selection is either fixed
// priority (lowest index wins) or round-robin starting at a rotation pointer
// that moves one past each new winner.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   req          request vector, bit i = requester i
//   done         pulsed by the current grantee on its last cycle of use
//   grant        one-hot registered grant (zero when nothing is granted)
//   grant_idx    binary index of the granted requester, qualified by grant_valid
//   grant_valid  high while a grant is held
//
// FSM:
//   state | meaning
//   IDLE  | no grant held, waiting for any request
//   BUSY  | grant held until done or the grantee abandons its request

module rr_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int RR_MODE = 1,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   base;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   ptr_next;
    logic [NUM_REQ-1:0] win_onehot;
    logic               hit;
    logic               any_req;
    logic               release_now;
    logic               arbitrate;

    // Two-pass search: first the lowest request at or above the pointer,
    // then, if nothing was found there, the lowest request overall (wrap).
    // In fixed-priority mode the search base is pinned to zero.
    always_comb begin
        base    = (RR_MODE != 0) ? ptr : '0;
        win_idx = '0;
        hit     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!hit && req[i] && (IDX_W'(i) >= base)) begin
                win_idx = IDX_W'(i);
                hit     = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!hit && req[i]) begin
                win_idx = IDX_W'(i);
                hit     = 1'b1;
            end
        end
    end

    assign any_req    = |req;
    assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
    assign ptr_next   = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;

    // Abandon (grantee's own request dropped) releases exactly like done.
    assign release_now = (state == BUSY) && (done || ((req & grant) == '0));

    // Re-arbitrating in the release cycle avoids an idle bubble between grants.
    assign arbitrate = any_req && ((state == IDLE) || release_now);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arbitrate) begin
                        grant       <= win_onehot;
                        grant_idx   <= win_idx;
                        grant_valid <= 1'b1;
                        state       <= BUSY;
                        if (RR_MODE != 0) ptr <= ptr_next;
                    end
                end
                BUSY: begin
                    if (arbitrate) begin
                        grant       <= win_onehot;
                        grant_idx   <= win_idx;
                        grant_valid <= 1'b1;
                        if (RR_MODE != 0) ptr <= ptr_next;
                    end else if (release_now) begin
                        // grant_idx keeps its last value; grant_valid qualifies it.
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
